// File: rtl/blood_ph_analyzer.sv
// blood_ph_analyzer
// Classifies 4-bit blood pH sample codes against a normal band [PH_LOW, PH_HIGH].
// It raises a registered acidic flag (abnormalityP) or alkaline flag (abnormalityQ),
// and outValid pulses for one cycle per accepted sample.
// Optional feature: define BLOOD_PH_ALARM_EN to build the consecutive-abnormal
// counter and the persistent alarm. Without it, alarm is tied to 0.
module blood_ph_analyzer #(
    parameter int unsigned PH_LOW      = 7,
    parameter int unsigned PH_HIGH     = 8,
    parameter int unsigned ALARM_COUNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       phValid,
    input  logic [3:0] bloodPH,
    output logic       abnormalityP,
    output logic       abnormalityQ,
    output logic       outValid,
    output logic       alarm
);

    // Thresholds narrowed to the sample width so comparisons stay 4-bit unsigned.
    localparam logic [3:0] PH_LOW_C    = 4'(PH_LOW);
    localparam logic [3:0] PH_HIGH_C   = 4'(PH_HIGH);
    localparam logic [2:0] ALARM_CNT_C = 3'(ALARM_COUNT);

    logic w_acidic;
    logic w_alkaline;
    logic r_acidic;
    logic r_alkaline;
    logic r_out_valid;

    // Because PH_HIGH >= PH_LOW, at most one of these can be true for any code.
    assign w_acidic   = (bloodPH < PH_LOW_C);
    assign w_alkaline = (bloodPH > PH_HIGH_C);

    // Capture the flags of each valid sample and hold them through idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acidic   <= 1'b0;
            r_alkaline <= 1'b0;
        end else if (phValid) begin
            // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
            r_acidic   <= w_acidic;
            r_alkaline <= w_alkaline;
        end
        // NOTE: the missing else is intentional. In a clocked block it means "hold", not a latch.
    end

    // The result-valid pulse follows the input strobe by exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= phValid;
        end
    end

    assign abnormalityP = r_acidic;
    assign abnormalityQ = r_alkaline;
    assign outValid     = r_out_valid;

`ifdef BLOOD_PH_ALARM_EN
    logic       w_abnormal;
    logic [2:0] r_abn_count;

    // Acidic and alkaline both count as abnormal, so switching sides keeps the run going.
    assign w_abnormal = w_acidic | w_alkaline;

    // Count consecutive valid abnormal samples, saturate at the threshold, and clear on a normal one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_abn_count <= 3'd0;
        end else if (phValid) begin
            if (!w_abnormal) begin
                r_abn_count <= 3'd0;
            end else if (r_abn_count != ALARM_CNT_C) begin
                r_abn_count <= r_abn_count + 3'd1;
            end
        end
    end

    // The alarm is decoded from the registered count, so it moves together with outValid.
    assign alarm = (r_abn_count == ALARM_CNT_C);
`else
    // The threshold is only meaningful with the alarm built in. This keeps it referenced.
    logic w_unused_alarm_cfg;
    assign w_unused_alarm_cfg = |ALARM_CNT_C;

    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_blood_ph_analyzer.sv
// Self-checking bench for blood_ph_analyzer (default parameters).
// The expected alarm behaviour follows BLOOD_PH_ALARM_EN, so the same bench covers both builds.
module tb_blood_ph_analyzer;

    localparam logic [3:0] PH_LOW      = 4'd7;
    localparam logic [3:0] PH_HIGH     = 4'd8;
    localparam int         ALARM_COUNT = 4;

    logic       clk;
    logic       rst_n;
    logic       phValid;
    logic [3:0] bloodPH;
    logic       abnormalityP;
    logic       abnormalityQ;
    logic       outValid;
    logic       alarm;

    typedef struct packed {
        logic p;
        logic q;
        logic alarm;
    } exp_t;

    exp_t sb_q[$];
    int   total;
    int   bad;
    int   m_cnt;

    blood_ph_analyzer #(
        .PH_LOW      (7),
        .PH_HIGH     (8),
        .ALARM_COUNT (ALARM_COUNT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .phValid      (phValid),
        .bloodPH      (bloodPH),
        .abnormalityP (abnormalityP),
        .abnormalityQ (abnormalityQ),
        .outValid     (outValid),
        .alarm        (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected alarm level for the current model count.
    function automatic logic model_alarm();
`ifdef BLOOD_PH_ALARM_EN
        return (m_cnt == ALARM_COUNT);
`else
        return 1'b0;
`endif
    endfunction

    // Drive one valid sample (called at a falling edge) and push its expected result.
    task automatic send(input logic [3:0] ph);
        exp_t e;
        phValid = 1'b1;
        bloodPH = ph;
        e.p = (ph < PH_LOW);
        e.q = (ph > PH_HIGH);
        if (e.p || e.q) begin
            if (m_cnt < ALARM_COUNT) m_cnt++;
        end else begin
            m_cnt = 0;
        end
        e.alarm = model_alarm();
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    // Drive one idle cycle with a given (ignored) sample code.
    task automatic idle(input logic [3:0] ph);
        phValid = 1'b0;
        bloodPH = ph;
        @(negedge clk);
    endtask

    // Scoreboard: each outValid pops one expected result, and a missing pulse is a failure.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n) begin
            if (outValid) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_outValid got=1 exp=0 at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    if ({abnormalityP, abnormalityQ, alarm} !== e) begin
                        bad++;
                        $display("FAIL result P/Q/alarm got=%b%b%b exp=%b%b%b at %0t",
                                 abnormalityP, abnormalityQ, alarm, e.p, e.q, e.alarm, $time);
                    end
                end
            end else if (sb_q.size() != 0) begin
                total++;
                bad++;
                e = sb_q.pop_front();
                $display("FAIL missing_outValid got=0 exp=1 (P/Q/alarm exp=%b%b%b) at %0t",
                         e.p, e.q, e.alarm, $time);
            end
        end
    end

    // Apply a clean reset and clear the model, ending at a falling edge with reset released.
    task automatic apply_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        phValid = 1'b0;
        m_cnt   = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        phValid = 1'b0;
        bloodPH = 4'd0;
        m_cnt   = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        total += 4;
        if (abnormalityP !== 1'b0) begin bad++; $display("FAIL reset_P got=%b exp=0", abnormalityP); end
        if (abnormalityQ !== 1'b0) begin bad++; $display("FAIL reset_Q got=%b exp=0", abnormalityQ); end
        if (outValid !== 1'b0) begin bad++; $display("FAIL reset_outValid got=%b exp=0", outValid); end
        if (alarm !== 1'b0) begin bad++; $display("FAIL reset_alarm got=%b exp=0", alarm); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Sample codes spanning both edges of the normal band, sent back to back.
    task automatic test_ranges();
        logic [3:0] codes [6];
        codes = '{4'd0, 4'd6, 4'd7, 4'd8, 4'd9, 4'd15};
        foreach (codes[i]) send(codes[i]);
        idle(4'd0);
    endtask

    // All sixteen codes with no gaps, so every result must appear with no stall.
    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) send(4'(i));
        idle(4'd0);
    endtask

    // Flags hold and outValid stays low while idle, even with an alkaline code on the bus.
    task automatic test_hold();
        logic exp_alarm;
        send(4'd6);
        exp_alarm = model_alarm();
        for (int i = 0; i < 3; i++) begin
            phValid = 1'b0;
            bloodPH = 4'd9;
            @(posedge clk);
            #2;
            total += 4;
            if (abnormalityP !== 1'b1) begin bad++; $display("FAIL hold_P idle=%0d got=%b exp=1", i, abnormalityP); end
            if (abnormalityQ !== 1'b0) begin bad++; $display("FAIL hold_Q idle=%0d got=%b exp=0", i, abnormalityQ); end
            if (outValid !== 1'b0) begin bad++; $display("FAIL hold_outValid idle=%0d got=%b exp=0", i, outValid); end
            if (alarm !== exp_alarm) begin bad++; $display("FAIL hold_alarm idle=%0d got=%b exp=%b", i, alarm, exp_alarm); end
            @(negedge clk);
        end
    endtask

    // Alternating acidic/alkaline samples keep counting, and a normal sample clears the run.
    task automatic test_alarm();
        apply_reset();
        send(4'd3);
        send(4'd12);
        send(4'd2);
        send(4'd10);
        send(4'd7);
        idle(4'd0);
    endtask

    // Idle cycles inside an abnormal run neither advance nor clear the count.
    task automatic test_idle_gap();
        apply_reset();
        send(4'd0);
        send(4'd0);
        send(4'd0);
        idle(4'd0);
        idle(4'd15);
        idle(4'd0);
        send(4'd0);
        send(4'd8);
        idle(4'd0);
    endtask

    // Reset between edges clears outputs at once, and the count restarts after release.
    task automatic test_reset_mid();
        apply_reset();
        send(4'd0);
        send(4'd15);
        send(4'd0);
        idle(4'd0);
        #2;
        rst_n = 1'b0;
        m_cnt = 0;
        #1;
        total += 4;
        if (abnormalityP !== 1'b0) begin bad++; $display("FAIL midreset_P got=%b exp=0", abnormalityP); end
        if (abnormalityQ !== 1'b0) begin bad++; $display("FAIL midreset_Q got=%b exp=0", abnormalityQ); end
        if (outValid !== 1'b0) begin bad++; $display("FAIL midreset_outValid got=%b exp=0", outValid); end
        if (alarm !== 1'b0) begin bad++; $display("FAIL midreset_alarm got=%b exp=0", alarm); end
        @(negedge clk);
        rst_n = 1'b1;
        send(4'd3);
        send(4'd14);
        send(4'd0);
        send(4'd9);
        idle(4'd0);
    endtask

    // A long alkaline run: Q on every result, and the alarm saturates (or stays 0 without the feature).
    task automatic test_saturate();
        apply_reset();
        for (int i = 0; i < 10; i++) send(4'd15);
        idle(4'd0);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        phValid = 1'b0;
        bloodPH = 4'd0;
        test_reset();
        test_ranges();
        test_back_to_back();
        test_hold();
        test_alarm();
        test_idle_gap();
        test_reset_mid();
        test_saturate();
        idle(4'd0);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drained_queue got=%0d exp=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/blood_ph_analyzer.md
BLOOD_PH_ANALYZER -- requirements
Module: blood_ph_analyzer

Interface
REQ-001 The block SHALL have parameter PH_LOW, default 7, the lowest normal pH code (unsigned, 0..15).
REQ-002 The block SHALL have parameter PH_HIGH, default 8, the highest normal pH code (unsigned, 0..15, PH_HIGH >= PH_LOW).
REQ-003 The block SHALL have parameter ALARM_COUNT, default 4, the number of consecutive abnormal samples that raise the alarm (legal 1..7).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port phValid, input, 1 bit: bloodPH carries a sample this cycle.
REQ-008 Port bloodPH, input, 4 bits: unsigned pH sample code.
REQ-009 Port abnormalityP, output, 1 bit: registered acidic flag (sample below normal range).
REQ-010 Port abnormalityQ, output, 1 bit: registered alkaline flag (sample above normal range).
REQ-011 Port outValid, output, 1 bit: one-cycle pulse marking freshly updated flags.
REQ-012 Port alarm, output, 1 bit: persistent-abnormality alarm (see Configuration).

Function
REQ-013 On a rising clk edge with phValid=1, abnormalityP SHALL load (bloodPH < PH_LOW) and abnormalityQ SHALL load (bloodPH > PH_HIGH), using unsigned 4-bit comparison.
REQ-014 Latency SHALL be exactly one cycle: flags and outValid=1 appear in the cycle after the one in which phValid=1 is sampled.
REQ-015 On an edge with phValid=0, abnormalityP and abnormalityQ SHALL hold their values and outValid SHALL be 0.
REQ-016 Back-to-back valid samples SHALL each produce one result, with no stall and no dropped sample.
REQ-017 With default parameters: codes 0..6 give P=1,Q=0; codes 7 and 8 give P=0,Q=0; codes 9..15 give P=0,Q=1.
REQ-018 abnormalityP and abnormalityQ SHALL never both be 1.
REQ-019 An internal 3-bit counter SHALL count consecutive valid abnormal samples (P or Q), increment on each, saturate at ALARM_COUNT, and clear to 0 on a valid normal sample.
REQ-020 Invalid cycles (phValid=0) SHALL leave the counter unchanged.
REQ-021 alarm SHALL be 1 exactly when the registered counter equals ALARM_COUNT, updating in the same cycle as outValid for the sample that reaches or leaves that value.
REQ-022 A switch between acidic and alkaline samples SHALL count as continued abnormality, so the counter is not cleared.

Reset
REQ-023 While rst_n=0, abnormalityP, abnormalityQ, outValid, alarm and the counter SHALL be 0, independent of clk.
REQ-024 Reset asserted mid-sequence SHALL discard any accumulated count, and the first valid sample after release SHALL be treated as count start.
REQ-025 The first valid sample SHALL be accepted on the first rising clk edge after rst_n goes high.

Configuration
REQ-026 Macro BLOOD_PH_ALARM_EN SHALL compile in the counter and alarm logic of REQ-019..REQ-022.
REQ-027 Without BLOOD_PH_ALARM_EN, the alarm port SHALL still exist and SHALL be tied to 0, no counter SHALL be built, and REQ-013..REQ-018 SHALL be unchanged.

Verification
REQ-028 Reset, then phValid=1 with bloodPH=0,6,7,8,9,15 on consecutive cycles -> one cycle later each: (P,Q)=(1,0),(1,0),(0,0),(0,0),(0,1),(0,1), with outValid=1 on all six cycles.
REQ-029 Sample bloodPH=6, then three idle cycles with phValid=0 while bloodPH=9 -> P=1,Q=0 held, outValid=0 during the idle cycles.
REQ-030 With the macro enabled, four consecutive valid samples 3,12,2,10 -> alarm=1 with the fourth result; a following sample of 7 -> alarm=0 and P=Q=0.
REQ-031 With the macro enabled, samples 0,0,0 then idle cycles then 0 -> alarm rises only with the fourth valid result.
REQ-032 Assert rst_n=0 between clock edges after three abnormal samples -> all outputs 0 immediately; after release, four more abnormal samples are needed to raise alarm.
REQ-033 Build without BLOOD_PH_ALARM_EN and apply ten samples of 15 -> Q=1 on each result, alarm stays 0.
